exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter MEM_LAT, default 1, data-memory wait cycles after request, legal 1..7.
REQ-003 Parameter RESET_PC, default 0, PC value after reset or upgrade.
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 upg_busy  in  1  UART program upload in progress, core held.
REQ-007 imem_rdata  in  XLEN  instruction word, valid one cycle after pc presented.
REQ-008 alu_result  in  XLEN  combinational ALU result / branch target for ir.
REQ-009 jump_flag  in  1  branch taken or jal/jalr, from ALU.
REQ-010 mem_rdata  in  XLEN  data-memory read word.
REQ-011 io_done  in  1  one-cycle pulse, ecall I/O complete.
REQ-012 io_data  in  XLEN  keyboard/switch value captured with io_done.
REQ-013 pc  out  XLEN  current PC, also instruction-memory address.
REQ-014 ir  out  XLEN  latched instruction, drives decoder.
REQ-015 mem_re, mem_we  out  1 each  one-cycle data-memory request strobes.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 rf_waddr  out  5  write register index.
REQ-018 rf_wdata  out  XLEN  write-back data.
REQ-019 state  out  3  FSM state code, debug LEDs.
REQ-020 retired  out  32  retired-instruction counter.

Function
REQ-021 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ECALL=5; codes 6-7 unreachable and SHALL recover to FETCH.
REQ-022 FETCH: pc presented; if upg_busy, stay in FETCH with pc forced to RESET_PC, else go to DECODE next cycle.
REQ-023 DECODE: ir <= imem_rdata; next EXEC.
REQ-024 EXEC: alu_q <= alu_result, jmp_q <= jump_flag; next state by ir[6:0]: 0x73 -> ECALL, 0x03 or 0x23 -> MEM, else WB.
REQ-025 MEM entry cycle: mem_re=1 for load or mem_we=1 for store, exactly one cycle; wait counter then counts MEM_LAT cycles.
REQ-026 MEM exit: load captures mem_rdata into mdr on final wait cycle and goes to WB; store updates pc to pc+4, increments retired, goes to FETCH.
REQ-027 WB: one cycle; rf_we=1 only if ir writes rd (opcodes 0x33,0x13,0x03,0x37,0x17,0x6F,0x67) and rd!=0; rf_waddr=ir[11:7].
REQ-028 rf_wdata in WB: jal/jalr -> pc+4; load -> mdr; else alu_q.
REQ-029 PC update at WB exit: jmp_q ? {alu_q[XLEN-1:2],2'b00} : pc+4, modulo 2^XLEN; retired +1 (wraps); next FETCH.
REQ-030 ECALL: hold all outputs, rf_we=0, until io_done; on io_done cycle rf_we=1, rf_waddr=10, rf_wdata=io_data, pc <= pc+4, retired +1, next FETCH.
REQ-031 io_done outside ECALL SHALL be ignored.
REQ-032 upg_busy asserted in any state other than FETCH: abort the instruction, no rf/mem strobes, next state FETCH, pc <= RESET_PC.
REQ-033 Minimum latency: ALU op 4 cycles, store 3+MEM_LAT, load 4+MEM_LAT, ecall 3+wait.
REQ-034 rf_we, mem_re and mem_we SHALL never be high in the same cycle.

Reset
REQ-035 rst high, at any time, asynchronously sets: state=FETCH, pc=RESET_PC, ir=0, alu_q=0, mdr=0, jmp_q=0, retired=0, mem_re=mem_we=rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-036 After rst deasserts, the first DECODE occurs on the second rising edge.

Verification
REQ-037 addi x1,x0,5 at pc 0 -> cycle 4 rf_we=1, rf_waddr=1, rf_wdata=5; pc=4; retired=1.
REQ-038 jal x1,+16 at pc 8 -> rf_wdata=12, pc=24, no write when rd=0 variant.
REQ-039 MEM_LAT=3, lw x2 with mem_rdata=0xDEADBEEF -> mem_re single pulse, WB at 7th cycle writes 0xDEADBEEF to x2.
REQ-040 ecall, io_done after 50 cycles with io_data=0x2A -> rf_we only on io_done cycle, x10 gets 0x2A, pc+4.
REQ-041 rst pulse during MEM wait of a store -> no further mem_we, pc=RESET_PC, retired=0.
REQ-042 upg_busy raised in EXEC -> no rf_we, state FETCH, pc held at RESET_PC until upg_busy falls.

Source files
------------

// File: rtl/exec_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : exec_sequencer_if                                           |
// | Brief  : Bundle between the multi-cycle execution sequencer and the  |
// |          surrounding core (imem, ALU, data memory, register file,    |
// |          ecall I/O and upload controller).                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface exec_sequencer_if #(
  parameter int XLEN = 32
);
  // Inputs to the sequencer
  logic            upg_busy;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] alu_result;
  logic            jump_flag;
  logic [XLEN-1:0] mem_rdata;
  logic            io_done;
  logic [XLEN-1:0] io_data;

  // Outputs from the sequencer
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic            mem_re;
  logic            mem_we;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [2:0]      state;
  logic [31:0]     retired;

  // Sequencer side
  modport master (
    input  upg_busy, imem_rdata, alu_result, jump_flag, mem_rdata, io_done, io_data,
    output pc, ir, mem_re, mem_we, rf_we, rf_waddr, rf_wdata, state, retired
  );

  // Core / environment side
  modport slave (
    output upg_busy, imem_rdata, alu_result, jump_flag, mem_rdata, io_done, io_data,
    input  pc, ir, mem_re, mem_we, rf_we, rf_waddr, rf_wdata, state, retired
  );
endinterface
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : exec_sequencer                                              |
// | Brief  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB/ECALL control FSM with |
// |          PC, instruction, ALU and memory-data latches and a retired  |
// |          instruction counter.                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module exec_sequencer #(
  parameter int              XLEN     = 32,
  parameter int              MEM_LAT  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  exec_sequencer_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ECALL  = 3'd5;

  localparam logic [6:0] c_op_load  = 7'h03;
  localparam logic [6:0] c_op_store = 7'h23;
  localparam logic [6:0] c_op_ecall = 7'h73;
  localparam logic [6:0] c_op_jal   = 7'h6F;
  localparam logic [6:0] c_op_jalr  = 7'h67;
  // The MEM state lasts MEM_LAT cycles; the first one carries the request.
  localparam logic [2:0] c_wait_last = 3'(MEM_LAT - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_alu_q;
  logic            r_jmp_q;
  logic [XLEN-1:0] r_mdr;
  logic [31:0]     r_retired;
  logic [2:0]      r_wait;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_link;
  logic            w_writes_rd;
  logic            w_wait_last;
  logic [XLEN-1:0] w_pc_plus4;

  logic            w_mem_re;
  logic            w_mem_we;
  logic            w_rf_we;
  logic [4:0]      w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;

  assign w_opcode    = r_ir[6:0];
  assign w_rd        = r_ir[11:7];
  assign w_is_load   = (w_opcode == c_op_load);
  assign w_is_store  = (w_opcode == c_op_store);
  assign w_is_link   = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr);
  assign w_writes_rd = (w_opcode == 7'h33) || (w_opcode == 7'h13) || w_is_load ||
                       (w_opcode == 7'h37) || (w_opcode == 7'h17) || w_is_link;
  assign w_wait_last = (r_wait == c_wait_last);
  assign w_pc_plus4  = r_pc + XLEN'(4);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; an upload request aborts whatever is in flight
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == c_op_ecall)      w_next_state = S_ECALL;
        else if (w_is_load || w_is_store) w_next_state = S_MEM;
        else                              w_next_state = S_WB;
      end
      S_MEM: begin
        if (w_wait_last) w_next_state = w_is_load ? S_WB : S_FETCH;
      end
      S_WB:    w_next_state = S_FETCH;
      S_ECALL: begin
        if (bus.io_done) w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
    if (bus.upg_busy) w_next_state = S_FETCH;
  end

  // Datapath latches: PC, IR, ALU/jump capture, memory data, wait counter, retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_alu_q   <= '0;
      r_jmp_q   <= 1'b0;
      r_mdr     <= '0;
      r_retired <= '0;
      r_wait    <= '0;
    end else if (bus.upg_busy) begin
      r_pc   <= RESET_PC;
      r_wait <= '0;
    end else begin
      case (r_state)
        S_DECODE: r_ir <= bus.imem_rdata;
        S_EXEC: begin
          r_alu_q <= bus.alu_result;
          r_jmp_q <= bus.jump_flag;
          r_wait  <= '0;
        end
        S_MEM: begin
          if (!w_wait_last) begin
            r_wait <= r_wait + 3'd1;
          end else if (w_is_load) begin
            r_mdr <= bus.mem_rdata;
          end else begin
            r_pc      <= w_pc_plus4;
            r_retired <= r_retired + 32'd1;
          end
        end
        S_WB: begin
          r_pc      <= r_jmp_q ? {r_alu_q[XLEN-1:2], 2'b00} : w_pc_plus4;
          r_retired <= r_retired + 32'd1;
        end
        S_ECALL: begin
          if (bus.io_done) begin
            r_pc      <= w_pc_plus4;
            r_retired <= r_retired + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and write-back bus; all suppressed while an upload is aborting the instruction
  always_comb begin
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    case (r_state)
      S_MEM: begin
        if (r_wait == 3'd0 && !bus.upg_busy) begin
          w_mem_re = w_is_load;
          w_mem_we = w_is_store;
        end
      end
      S_WB: begin
        w_rf_waddr = w_rd;
        if (w_is_link)      w_rf_wdata = w_pc_plus4;
        else if (w_is_load) w_rf_wdata = r_mdr;
        else                w_rf_wdata = r_alu_q;
        w_rf_we = w_writes_rd && (w_rd != 5'd0) && !bus.upg_busy;
      end
      S_ECALL: begin
        if (bus.io_done && !bus.upg_busy) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = 5'd10;
          w_rf_wdata = bus.io_data;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc       = r_pc;
  assign bus.ir       = r_ir;
  assign bus.mem_re   = w_mem_re;
  assign bus.mem_we   = w_mem_we;
  assign bus.rf_we    = w_rf_we;
  assign bus.rf_waddr = w_rf_waddr;
  assign bus.rf_wdata = w_rf_wdata;
  assign bus.state    = r_state;
  assign bus.retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_exec_sequencer                                           |
// | Brief  : Self-checking bench for exec_sequencer; an instruction-     |
// |          level model predicts the per-cycle trace of each directed   |
// |          instruction, plus hand-computed literal expectations.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_exec_sequencer;

  localparam int MEM_LAT = 3;
  localparam int MAXC    = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exec_sequencer_if #(.XLEN(32)) bus ();

  exec_sequencer #(.XLEN(32), .MEM_LAT(MEM_LAT), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle trace of the instruction in flight
  logic [2:0]  e_st  [MAXC];
  logic        e_rfwe[MAXC];
  logic        e_re  [MAXC];
  logic        e_we  [MAXC];
  logic [4:0]  e_wa  [MAXC];
  logic [31:0] e_wd  [MAXC];
  logic [31:0] e_pc  [MAXC];
  logic [31:0] e_ret [MAXC];
  int          e_len = 0;
  int          cyc   = 0;
  bit          chk_en = 0;

  // Architectural model state
  logic [31:0] pc_m  = 32'h0;
  logic [31:0] ret_m = 32'h0;

  // Observed write/strobe history
  int          n_rfwe = 0, n_re = 0, n_we = 0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t cyc=%0d actual=%h required=%h", name, $time, cyc, act, exp);
    end
  endtask

  // Instruction-level model: F, D, E, then class-specific phase lengths
  task automatic build_model(input logic [31:0] instr, input logic [31:0] alu, input logic jmp,
                             input logic [31:0] mdata, input logic [31:0] iod, input int io_wait,
                             input int abort_at, input int upg_len);
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] npc;
    bit          writes;
    int          n;
    op     = instr[6:0];
    rd     = instr[11:7];
    writes = op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    for (int i = 0; i < MAXC; i++) begin
      e_st[i] = 3'd0; e_rfwe[i] = 1'b0; e_re[i] = 1'b0; e_we[i] = 1'b0;
      e_wa[i] = '0;   e_wd[i] = '0;     e_pc[i] = pc_m;  e_ret[i] = ret_m;
    end
    e_st[0] = 3'd0; e_st[1] = 3'd1; e_st[2] = 3'd2;
    n   = 3;
    npc = pc_m + 32'd4;
    if (op == 7'h73) begin
      for (int k = 0; k <= io_wait; k++) begin e_st[n] = 3'd5; n++; end
      e_rfwe[n-1] = 1'b1; e_wa[n-1] = 5'd10; e_wd[n-1] = iod;
    end else if (op == 7'h03 || op == 7'h23) begin
      e_re[3] = (op == 7'h03);
      e_we[3] = (op == 7'h23);
      for (int k = 0; k < MEM_LAT; k++) begin e_st[n] = 3'd3; n++; end
      if (op == 7'h03) begin
        e_st[n] = 3'd4; e_rfwe[n] = (rd != 0); e_wa[n] = rd; e_wd[n] = mdata; n++;
      end
    end else begin
      e_st[n]   = 3'd4;
      e_rfwe[n] = writes && (rd != 0);
      e_wa[n]   = rd;
      e_wd[n]   = (op == 7'h6F || op == 7'h67) ? pc_m + 32'd4 : alu;
      if (jmp) npc = {alu[31:2], 2'b00};
      n++;
    end
    if (abort_at >= 0) begin
      e_rfwe[abort_at] = 1'b0; e_re[abort_at] = 1'b0; e_we[abort_at] = 1'b0;
      n = abort_at + upg_len;
      for (int i = abort_at + 1; i < MAXC; i++) begin
        e_st[i] = 3'd0; e_pc[i] = 32'h0; e_rfwe[i] = 1'b0; e_re[i] = 1'b0; e_we[i] = 1'b0;
      end
      npc = 32'h0;
    end else begin
      ret_m = ret_m + 32'd1;
    end
    e_len = n;
    pc_m  = npc;
  endtask

  // Drives one instruction from its FETCH cycle up to the next FETCH cycle
  task automatic run(input logic [31:0] instr, input logic [31:0] alu, input logic jmp,
                     input logic [31:0] mdata, input logic [31:0] iod, input int io_wait,
                     input int abort_at, input int upg_len);
    build_model(instr, alu, jmp, mdata, iod, io_wait, abort_at, upg_len);
    bus.imem_rdata = instr;
    bus.alu_result = alu;
    bus.jump_flag  = jmp;
    bus.mem_rdata  = mdata;
    bus.io_data    = iod;
    cyc    = 0;
    chk_en = 1;
    for (int i = 0; i < e_len; i++) begin
      // For ecall, io_done is also held high through F/D/E where it must be ignored
      bus.io_done  = (instr[6:0] == 7'h73) ? (i < 3 || i == 3 + io_wait) : 1'b0;
      bus.upg_busy = (abort_at >= 0 && i >= abort_at && i < abort_at + upg_len);
      @(posedge clk); #1;
    end
    bus.io_done  = 1'b0;
    bus.upg_busy = 1'b0;
    chk_en = 0;
  endtask

  int w0;

  initial begin
    bus.upg_busy = 1'b0; bus.imem_rdata = '0; bus.alu_result = '0; bus.jump_flag = 1'b0;
    bus.mem_rdata = '0;  bus.io_done = 1'b0;  bus.io_data = '0;

    // Compare process: checks the DUT against the model every cycle on the falling edge
    fork
      forever begin
        @(negedge clk);
        if (bus.rf_we)  begin n_rfwe++; last_wa = bus.rf_waddr; last_wd = bus.rf_wdata; end
        if (bus.mem_re) n_re++;
        if (bus.mem_we) n_we++;
        if (chk_en && cyc < e_len) begin
          chk("state",   32'(bus.state),  32'(e_st[cyc]));
          chk("pc",      bus.pc,          e_pc[cyc]);
          chk("retired", bus.retired,     e_ret[cyc]);
          chk("rf_we",   32'(bus.rf_we),  32'(e_rfwe[cyc]));
          chk("mem_re",  32'(bus.mem_re), 32'(e_re[cyc]));
          chk("mem_we",  32'(bus.mem_we), 32'(e_we[cyc]));
          chk("strobe_exclusive", 32'(32'(bus.rf_we) + 32'(bus.mem_re) + 32'(bus.mem_we) > 1), 32'd0);
          if (e_rfwe[cyc]) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(e_wa[cyc]));
            chk("rf_wdata", bus.rf_wdata,      e_wd[cyc]);
          end
          cyc++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",   32'(bus.state),  32'd0);
    chk("rst_pc",      bus.pc,          32'h0);
    chk("rst_ir",      bus.ir,          32'h0);
    chk("rst_retired", bus.retired,     32'h0);
    chk("rst_rf_we",   32'(bus.rf_we),  32'd0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5 at pc 0
    run(32'h00500093, 32'd5, 1'b0, '0, '0, 0, -1, 0);
    chk("addi_pc", bus.pc, 32'h4);
    chk("addi_retired", bus.retired, 32'd1);
    chk("addi_waddr", 32'(last_wa), 32'd1);
    chk("addi_wdata", last_wd, 32'd5);
    chk("addi_ir", bus.ir, 32'h00500093);

    // addi x2,x0,7 at pc 4
    run(32'h00700113, 32'd7, 1'b0, '0, '0, 0, -1, 0);

    // jal x1,+16 at pc 8
    run(32'h010000EF, 32'd24, 1'b1, '0, '0, 0, -1, 0);
    chk("jal_wdata", last_wd, 32'd12);
    chk("jal_waddr", 32'(last_wa), 32'd1);
    chk("jal_pc", bus.pc, 32'd24);

    // jal x0,+16 at pc 24: no register write
    w0 = n_rfwe;
    run(32'h0100006F, 32'd40, 1'b1, '0, '0, 0, -1, 0);
    chk("jal_x0_nowrite", 32'(n_rfwe - w0), 32'd0);
    chk("jal_x0_pc", bus.pc, 32'd40);

    // lw x2,0(x0) with MEM_LAT=3
    w0 = n_re;
    run(32'h00002103, 32'h100, 1'b0, 32'hDEADBEEF, '0, 0, -1, 0);
    chk("lw_mem_re_pulses", 32'(n_re - w0), 32'd1);
    chk("lw_waddr", 32'(last_wa), 32'd2);
    chk("lw_wdata", last_wd, 32'hDEADBEEF);
    chk("lw_pc", bus.pc, 32'd44);

    // sw x2,0(x0)
    w0 = n_we;
    run(32'h00202023, 32'h104, 1'b0, '0, '0, 0, -1, 0);
    chk("sw_mem_we_pulses", 32'(n_we - w0), 32'd1);
    chk("sw_pc", bus.pc, 32'd48);

    // taken branch to an unaligned target: low bits cleared
    run(32'h00000063, 32'h83, 1'b1, '0, '0, 0, -1, 0);
    chk("beq_pc", bus.pc, 32'h80);

    // ecall, io_done after 50 waiting cycles
    w0 = n_rfwe;
    run(32'h00000073, '0, 1'b0, '0, 32'h2A, 50, -1, 0);
    chk("ecall_one_write", 32'(n_rfwe - w0), 32'd1);
    chk("ecall_waddr", 32'(last_wa), 32'd10);
    chk("ecall_wdata", last_wd, 32'h2A);
    chk("ecall_pc", bus.pc, 32'h84);
    chk("ecall_retired", bus.retired, 32'd8);

    // upg_busy raised in EXEC of addi x3 and held 4 cycles
    w0 = n_rfwe;
    run(32'h00300193, 32'd9, 1'b0, '0, '0, 0, 2, 4);
    chk("upg_nowrite", 32'(n_rfwe - w0), 32'd0);
    chk("upg_pc", bus.pc, 32'h0);
    chk("upg_retired", bus.retired, 32'd8);

    // Recovery after upload
    run(32'h00500093, 32'd5, 1'b0, '0, '0, 0, -1, 0);
    chk("recover_pc", bus.pc, 32'h4);

    // rst pulse during the MEM wait of a store
    bus.imem_rdata = 32'h00202023;
    bus.alu_result = 32'h104;
    bus.jump_flag  = 1'b0;
    w0 = n_we;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pc", bus.pc, 32'h0);
    chk("rst_async_retired", bus.retired, 32'h0);
    chk("rst_async_state", 32'(bus.state), 32'd0);
    chk("rst_async_mem_we", 32'(bus.mem_we), 32'd0);
    bus.imem_rdata = 32'h00000013;
    bus.alu_result = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_store_we_pulses", 32'(n_we - w0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
